// File: rtl/clock_frequency_divider.sv
// Counter/toggle divider: turns InClock into a registered 50%-duty OutClock
// at CLOCK_FREQUENCY/(2*HALF_PERIOD) Hz for the slow layout-update domain.
module clock_frequency_divider #(
    parameter int CLOCK_FREQUENCY  = 50_000_000,
    parameter int OUTPUT_FREQUENCY = 1
) (
    input  logic InClock,
    input  logic reset,
    output logic OutClock
);

    localparam int HALF_PERIOD   = CLOCK_FREQUENCY / (2 * OUTPUT_FREQUENCY);
    localparam int COUNTER_WIDTH = $clog2(HALF_PERIOD) + 1;

    // Clamp keeps the terminal count well-formed while the error below fires.
    localparam int HP_SAFE = (HALF_PERIOD < 1) ? 1 : HALF_PERIOD;
    localparam logic [COUNTER_WIDTH-1:0] LAST_COUNT = COUNTER_WIDTH'(HP_SAFE - 1);
    localparam logic [COUNTER_WIDTH-1:0] ONE        = COUNTER_WIDTH'(1);

    if (HALF_PERIOD < 1) begin : g_bad_ratio
        $error("clock_frequency_divider: OUTPUT_FREQUENCY exceeds CLOCK_FREQUENCY/2");
    end

    logic [COUNTER_WIDTH-1:0] counter_q;
    logic [COUNTER_WIDTH-1:0] counter_d;
    logic                     out_clock_q;
    logic                     out_clock_d;

    always_comb begin
        counter_d   = counter_q + ONE;
        out_clock_d = out_clock_q;
        if (counter_q == LAST_COUNT) begin
            counter_d   = '0;
            out_clock_d = ~out_clock_q;
        end
    end

    always_ff @(posedge InClock or posedge reset) begin
        if (reset) begin
            counter_q   <= '0;
            out_clock_q <= 1'b0;
        end else begin
            counter_q   <= counter_d;
            out_clock_q <= out_clock_d;
        end
    end

    assign OutClock = out_clock_q;

endmodule

// File: tb/tb_clock_frequency_divider.sv
// Bench for clock_frequency_divider: three ratios (5, 1, truncated 5) driven
// together with random reset points, checked against an edge-count model.
module tb_clock_frequency_divider;

    logic clk;
    logic rst;
    logic out_hp5;
    logic out_hp1;
    logic out_trunc;

    int compared   = 0;
    int mismatched = 0;
    int n_edges    = 0;

    localparam int HP5   = 100 / (2 * 10);
    localparam int HP1   = 2 / (2 * 1);
    localparam int HPTRN = 105 / (2 * 10);

    clock_frequency_divider #(
        .CLOCK_FREQUENCY (100),
        .OUTPUT_FREQUENCY(10)
    ) u_hp5 (
        .InClock (clk),
        .reset   (rst),
        .OutClock(out_hp5)
    );

    clock_frequency_divider #(
        .CLOCK_FREQUENCY (2),
        .OUTPUT_FREQUENCY(1)
    ) u_hp1 (
        .InClock (clk),
        .reset   (rst),
        .OutClock(out_hp1)
    );

    clock_frequency_divider #(
        .CLOCK_FREQUENCY (105),
        .OUTPUT_FREQUENCY(10)
    ) u_trunc (
        .InClock (clk),
        .reset   (rst),
        .OutClock(out_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // After n rising edges out of reset the output has toggled n/hp times.
    function automatic logic model(int n, int hp);
        return ((n / hp) % 2) == 1;
    endfunction

    task automatic check(string tag, logic obs, logic exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s edge=%0d: observed %b expected %b",
                   tag, n_edges, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, "/hp5"},   out_hp5,   model(n_edges, HP5));
        check({tag, "/hp1"},   out_hp1,   model(n_edges, HP1));
        check({tag, "/trunc"}, out_trunc, model(n_edges, HPTRN));
    endtask

    task automatic check_zero(string tag);
        check({tag, "/hp5"},   out_hp5,   1'b0);
        check({tag, "/hp1"},   out_hp1,   1'b0);
        check({tag, "/trunc"}, out_trunc, 1'b0);
    endtask

    task automatic run_edges(int count, string tag);
        for (int i = 0; i < count; i++) begin
            @(posedge clk);
            #1;
            n_edges++;
            check_all(tag);
        end
    endtask

    // Assert reset between edges, check it acts at once and holds, then
    // release between edges so the next posedge is edge 1.
    task automatic pulse_reset(int hold_edges, string tag);
        rst = 1'b1;
        #1;
        check_zero({tag, "_imm"});
        for (int i = 0; i < hold_edges; i++) begin
            @(posedge clk);
            #1;
            check_zero({tag, "_held"});
        end
        @(negedge clk);
        rst     = 1'b0;
        n_edges = 0;
        #1;
        check_all({tag, "_rel"});
    endtask

    initial begin
        rst = 1'b0;
        #2;
        pulse_reset(3, "por");

        // Rise on 5th edge, fall on 10th, then five full periods.
        run_edges(4, "pre_rise");
        run_edges(1, "rise5");
        check("rise5_hi", out_hp5, 1'b1);
        run_edges(5, "fall10");
        check("fall10_lo", out_hp5, 1'b0);
        run_edges(50, "steady");

        // Land on the 3rd cycle of an hp5 high phase, then reset mid-cycle.
        while ((n_edges % 10) != 7) run_edges(1, "seek");
        check("mid_high", out_hp5, 1'b1);
        @(negedge clk);
        pulse_reset(2, "midhigh");
        run_edges(4, "re_pre");
        run_edges(1, "re_rise5");
        check("re_rise5_hi", out_hp5, 1'b1);

        // Random run lengths and reset points within the cycle.
        for (int r = 0; r < 12; r++) begin
            run_edges($urandom_range(1, 35), "rand");
            #($urandom_range(1, 7));
            pulse_reset($urandom_range(0, 3), "rand_rst");
        end
        run_edges(40, "tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed still running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
